cp0_reg: RTL and testbench

//  MIPS32 coprocessor-0 register file; terminal consumer of the CP0-write and exception fields

---
 rtl/cp0_reg_pkg.sv | 55 +++++
 rtl/cp0_reg_if.sv | 35 +++
 rtl/cp0_reg_timer.sv | 32 +++
 rtl/cp0_reg.sv | 96 +++++++++
 tb/tb_cp0_reg.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared constants for the CP0 register file: register numbers, exception-type
// codes, ExcCode values and Status/Cause bit positions.
package cp0_reg_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;
  localparam logic [4:0] CP0_CONFIG  = 5'd16;

  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_RI        = 32'h0000_000a;
  localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;
  localparam logic [4:0] CODE_TRAP = 5'd13;

  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_IV   = 23;
  localparam int CAUSE_WP   = 22;

  typedef enum logic [1:0] {EXC_NONE, EXC_TAKE, EXC_RET} exc_kind_e;

  typedef struct packed {
    exc_kind_e  kind;
    logic [4:0] code;
  } exc_dec_t;

  // Unknown exception types decode to EXC_NONE and are dropped.
  function automatic exc_dec_t decode_exc(logic [31:0] t);
    exc_dec_t d;
    d.kind = EXC_NONE;
    d.code = CODE_INT;
    case (t)
      EXC_INTERRUPT: begin d.kind = EXC_TAKE; d.code = CODE_INT;  end
      EXC_SYSCALL:   begin d.kind = EXC_TAKE; d.code = CODE_SYS;  end
      EXC_RI:        begin d.kind = EXC_TAKE; d.code = CODE_RI;   end
      EXC_OVERFLOW:  begin d.kind = EXC_TAKE; d.code = CODE_OV;   end
      EXC_TRAP:      begin d.kind = EXC_TAKE; d.code = CODE_TRAP; end
      EXC_ERET:      d.kind = EXC_RET;
      default:       d.kind = EXC_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// Pipeline-facing bundle of the CP0 register file: commit/write/read inputs and
// register-content outputs.
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] config_o;
  logic [31:0] prid_o;
  logic        timer_int_o;

  modport master (
    output we_i, waddr_i, data_i, raddr_i, int_i, excepttype_i,
           current_inst_addr_i, is_in_delayslot_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o,
           config_o, prid_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, data_i, raddr_i, int_i, excepttype_i,
           current_inst_addr_i, is_in_delayslot_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o,
           config_o, prid_o, timer_int_o
  );
endinterface

// File: rtl/cp0_reg_timer.sv
// Count/Compare timer: free-running Count, Compare match raises timer_int which
// stays set until Compare is rewritten.
module cp0_reg_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count <= '0;
    else if (count_we) count <= wdata;
    else               count <= count + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             compare <= '0;
    else if (compare_we) compare <= wdata;
  end

  // A Compare write clears the interrupt even if a match lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     timer_int <= 1'b0;
    else if (compare_we)                         timer_int <= 1'b0;
    else if (compare != '0 && count == compare)  timer_int <= 1'b1;
  end

endmodule

// File: rtl/cp0_reg.sv
// MIPS32 CP0 register file: commits mtc0 writes and precise-exception side
// effects, runs the timer, samples interrupts and serves mfc0 reads.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
  input logic        clk,
  input logic        rst,
  cp0_reg_if.slave   bus
);

  logic [31:0] count, compare, status, cause, epc;
  logic        timer_int;
  exc_dec_t    exc;

  assign exc = decode_exc(bus.excepttype_i);

  function automatic logic hit(logic [4:0] a);
    return bus.we_i && (bus.waddr_i == a);
  endfunction

  cp0_reg_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (hit(CP0_COUNT)),
    .compare_we (hit(CP0_COMPARE)),
    .wdata      (bus.data_i),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  // Exception updates follow the write so they win on overlapping bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) status <= STATUS_RESET;
    else begin
      if (hit(CP0_STATUS))    status <= bus.data_i;
      if (exc.kind == EXC_TAKE) status[STATUS_EXL] <= 1'b1;
      else if (exc.kind == EXC_RET) status[STATUS_EXL] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cause <= '0;
    else begin
      cause[15:10] <= bus.int_i;
      if (hit(CP0_CAUSE)) begin
        cause[9:8]      <= bus.data_i[9:8];
        cause[CAUSE_WP] <= bus.data_i[CAUSE_WP];
        cause[CAUSE_IV] <= bus.data_i[CAUSE_IV];
      end
      if (exc.kind == EXC_TAKE) begin
        cause[6:2] <= exc.code;
        if (!status[STATUS_EXL]) cause[CAUSE_BD] <= bus.is_in_delayslot_i;
      end
    end
  end

  // A nested exception (EXL already set) keeps the original return address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) epc <= '0;
    else begin
      if (hit(CP0_EPC)) epc <= bus.data_i;
      if (exc.kind == EXC_TAKE && !status[STATUS_EXL])
        epc <= bus.is_in_delayslot_i ? bus.current_inst_addr_i - 32'd4
                                     : bus.current_inst_addr_i;
    end
  end

  always_comb begin
    bus.data_o = '0;
    case (bus.raddr_i)
      CP0_COUNT:   bus.data_o = count;
      CP0_COMPARE: bus.data_o = compare;
      CP0_STATUS:  bus.data_o = status;
      CP0_CAUSE:   bus.data_o = cause;
      CP0_EPC:     bus.data_o = epc;
      CP0_PRID:    bus.data_o = PRID_VALUE;
      CP0_CONFIG:  bus.data_o = CONFIG_VALUE;
      default:     bus.data_o = '0;
    endcase
  end

  assign bus.count_o     = count;
  assign bus.compare_o   = compare;
  assign bus.status_o    = status;
  assign bus.cause_o     = cause;
  assign bus.epc_o       = epc;
  assign bus.config_o    = CONFIG_VALUE;
  assign bus.prid_o      = PRID_VALUE;
  assign bus.timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: expectations queued with each stimulus step and
// drained against DUT outputs once the step has been clocked.
module tb_cp0_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp0_reg_if bus();

  cp0_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef enum {O_COUNT, O_COMPARE, O_STATUS, O_CAUSE, O_EPC,
                O_CONFIG, O_PRID, O_DATA, O_TIMER} sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] PRID   = 32'h004c0102;
  localparam logic [31:0] CONFIG = 32'h00008000;
  localparam logic [31:0] ST_RST = 32'h10000000;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      O_COUNT:   return bus.count_o;
      O_COMPARE: return bus.compare_o;
      O_STATUS:  return bus.status_o;
      O_CAUSE:   return bus.cause_o;
      O_EPC:     return bus.epc_o;
      O_CONFIG:  return bus.config_o;
      O_PRID:    return bus.prid_o;
      O_DATA:    return bus.data_o;
      default:   return {31'b0, bus.timer_int_o};
    endcase
  endfunction

  task automatic push_exp(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we_i    = 1'b1;
    bus.waddr_i = a;
    bus.data_i  = d;
  endtask

  task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds);
    bus.excepttype_i        = t;
    bus.current_inst_addr_i = pc;
    bus.is_in_delayslot_i   = ds;
  endtask

  task automatic idle();
    bus.we_i         = 1'b0;
    bus.excepttype_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.we_i = 1'b0; bus.waddr_i = '0; bus.data_i = '0; bus.raddr_i = 5'd12;
    bus.int_i = '0; bus.excepttype_i = '0; bus.current_inst_addr_i = '0;
    bus.is_in_delayslot_i = 1'b0;

    // Reset state
    repeat (2) tick();
    push_exp("rst_count", O_COUNT, 32'd0);
    push_exp("rst_status", O_STATUS, ST_RST);
    push_exp("rst_cause", O_CAUSE, 32'd0);
    push_exp("rst_epc", O_EPC, 32'd0);
    push_exp("rst_timer", O_TIMER, 32'd0);
    push_exp("rst_data_status", O_DATA, ST_RST);
    push_exp("rst_config", O_CONFIG, CONFIG);
    check_all();
    rst = 1'b0;

    // Idle 5 cycles
    bus.raddr_i = 5'd15;
    repeat (5) tick();
    push_exp("idle_count", O_COUNT, 32'd5);
    push_exp("idle_status", O_STATUS, ST_RST);
    push_exp("idle_timer", O_TIMER, 32'd0);
    push_exp("idle_data_prid", O_DATA, PRID);
    check_all();

    // Timer: Count=0, Compare=20, run to match
    wr(5'd9, 32'd0);   tick();
    wr(5'd11, 32'd20); tick();
    idle();
    push_exp("tmr_count1", O_COUNT, 32'd1);
    push_exp("tmr_compare", O_COMPARE, 32'd20);
    check_all();
    repeat (19) tick();
    push_exp("tmr_count20", O_COUNT, 32'd20);
    push_exp("tmr_not_yet", O_TIMER, 32'd0);
    check_all();
    tick();
    push_exp("tmr_fired", O_TIMER, 32'd1);
    check_all();
    repeat (3) tick();
    push_exp("tmr_held", O_TIMER, 32'd1);
    check_all();
    wr(5'd11, 32'd100); tick(); idle();
    push_exp("tmr_cleared", O_TIMER, 32'd0);
    push_exp("tmr_compare100", O_COMPARE, 32'd100);
    check_all();

    // Count wrap
    wr(5'd9, 32'hFFFF_FFFF); tick(); idle();
    push_exp("wrap_max", O_COUNT, 32'hFFFF_FFFF);
    check_all();
    tick();
    push_exp("wrap_zero", O_COUNT, 32'd0);
    check_all();

    // Read-only / unmapped
    wr(5'd15, 32'hDEAD_BEEF); tick();
    wr(5'd3, 32'hDEAD_BEEF);  tick(); idle();
    bus.raddr_i = 5'd15; #1;
    push_exp("prid_ro", O_DATA, PRID);
    check_all();
    bus.raddr_i = 5'd3; #1;
    push_exp("unmapped_rd", O_DATA, 32'd0);
    check_all();

    // Syscall in delay slot, EXL=0
    bus.raddr_i = 5'd14;
    exc(32'h8, 32'h8000_1000, 1'b1); tick(); idle();
    push_exp("sys1_epc", O_EPC, 32'h8000_0FFC);
    push_exp("sys1_cause", O_CAUSE, 32'h8000_0020);
    push_exp("sys1_status", O_STATUS, 32'h1000_0002);
    push_exp("sys1_data_epc", O_DATA, 32'h8000_0FFC);
    check_all();

    // Nested syscall with EXL=1
    exc(32'h8, 32'h8000_2000, 1'b0); tick(); idle();
    push_exp("sys2_epc", O_EPC, 32'h8000_0FFC);
    push_exp("sys2_cause", O_CAUSE, 32'h8000_0020);
    push_exp("sys2_status", O_STATUS, 32'h1000_0002);
    check_all();

    // eret
    exc(32'he, 32'h0, 1'b0); tick(); idle();
    push_exp("eret_status", O_STATUS, ST_RST);
    push_exp("eret_epc", O_EPC, 32'h8000_0FFC);
    push_exp("eret_cause", O_CAUSE, 32'h8000_0020);
    check_all();

    // Unknown exception code ignored
    exc(32'h5, 32'h1234, 1'b0); tick(); idle();
    push_exp("unk_status", O_STATUS, ST_RST);
    push_exp("unk_epc", O_EPC, 32'h8000_0FFC);
    check_all();

    // Mid-run reset is asynchronous
    #2; rst = 1'b1; #1;
    push_exp("arst_count", O_COUNT, 32'd0);
    push_exp("arst_status", O_STATUS, ST_RST);
    push_exp("arst_cause", O_CAUSE, 32'd0);
    push_exp("arst_epc", O_EPC, 32'd0);
    push_exp("arst_compare", O_COMPARE, 32'd0);
    check_all();
    tick(); rst = 1'b0;

    // Cause write keeps only soft IP, WP, IV; IP[15:10] from int_i
    bus.int_i = 6'b101010;
    wr(5'd13, 32'hFFFF_FFFF); tick(); idle();
    push_exp("cause_wr", O_CAUSE,
             (32'd1 << 23) | (32'd1 << 22) | (32'd1 << 15) | (32'd1 << 13) |
             (32'd1 << 11) | (32'd1 << 9) | (32'd1 << 8));
    check_all();

    // Status write plus overflow on the same edge
    wr(5'd12, 32'h0);
    exc(32'hc, 32'h0000_0100, 1'b0); tick(); idle();
    push_exp("ov_status", O_STATUS, 32'h0000_0002);
    push_exp("ov_cause", O_CAUSE, 32'h00C0_AB30);
    push_exp("ov_epc", O_EPC, 32'h0000_0100);
    check_all();

    // Reset clears everything again
    #2; rst = 1'b1; #1;
    push_exp("arst2_status", O_STATUS, ST_RST);
    push_exp("arst2_cause", O_CAUSE, 32'd0);
    push_exp("arst2_epc", O_EPC, 32'd0);
    push_exp("arst2_timer", O_TIMER, 32'd0);
    push_exp("arst2_prid", O_PRID, PRID);
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
